// File: rtl/cam_ctrl_pkg.sv
// rtl/cam_ctrl_pkg.sv - shared state type and constants for the CAM controller
package cam_ctrl_pkg;

  localparam int DATA_PER_BLOCK     = 7;
  localparam int CAM_LOOKUP_LATENCY = 2;
  localparam int DRAIN_CNT_W        = $clog2(CAM_LOOKUP_LATENCY) + 1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DRAIN,
    WRITE,
    WAIT_LO,
    WAIT_HI
  } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - lowest-index priority encoder over CAM match lines
module cam_prio_enc #(
  parameter  int ADDR_WIDTH = 5,
  localparam int WORDS      = 1 << ADDR_WIDTH
) (
  input  logic [WORDS-1:0]      match_lines,
  output logic                  hit,
  output logic                  multi,
  output logic [ADDR_WIDTH-1:0] index
);

  // Clearing the lowest set bit leaves something only when two or more lines match;
  // the downward scan leaves the lowest matching index in place.
  always_comb begin
    hit   = |match_lines;
    multi = |(match_lines & (match_lines - WORDS'(1)));
    index = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (match_lines[i]) begin
        index = ADDR_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/cam_controller.sv
// rtl/cam_controller.sv - write arbitration and lookup sequencing in front of ram_based_cam
module cam_controller
  import cam_ctrl_pkg::*;
#(
  parameter  int DATA_BLOCKS = 5,
  parameter  int ADDR_WIDTH  = 5,
  localparam int DATA_WIDTH  = DATA_PER_BLOCK * DATA_BLOCKS,
  localparam int WORDS       = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [DATA_WIDTH-1:0] req0_care,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [DATA_WIDTH-1:0] req1_care,
  input  logic                  lk_valid,
  output logic                  lk_ready,
  input  logic [DATA_WIDTH-1:0] lk_data,
  output logic                  res_valid,
  output logic                  res_hit,
  output logic                  res_multi,
  output logic [ADDR_WIDTH-1:0] res_index,
  output logic [ADDR_WIDTH-1:0] cam_waddr,
  output logic [DATA_WIDTH-1:0] cam_wdata,
  output logic [DATA_WIDTH-1:0] cam_wcare,
  output logic                  cam_start_write,
  input  logic                  cam_ready,
  output logic [DATA_WIDTH-1:0] cam_lookup_data,
  input  logic [WORDS-1:0]      cam_match_lines,
  output logic                  busy
);

  cam_state_e                        state, state_nxt;
  logic                              last_grant;
  logic                              grant_any;
  logic                              grant_sel;
  logic [DRAIN_CNT_W-1:0]            drain_cnt;
  logic                              lk_issue;
  logic [CAM_LOOKUP_LATENCY-1:0]     tok_pipe;
  logic                              pipe_busy;
  logic                              enc_hit;
  logic                              enc_multi;
  logic [ADDR_WIDTH-1:0]             enc_index;

  // Tokens still in front of the last stage would see the CAM mid-write.
  assign pipe_busy = lk_issue | (|tok_pipe[CAM_LOOKUP_LATENCY-2:0]);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, round-robin grant and handshake outputs; writes beat lookups in IDLE.
  always_comb begin
    state_nxt       = state;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    lk_ready        = 1'b0;
    grant_any       = 1'b0;
    grant_sel       = 1'b0;
    cam_start_write = 1'b0;
    case (state)
      INIT: begin
        if (cam_ready) state_nxt = IDLE;
      end
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_any  = 1'b1;
          grant_sel  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          state_nxt  = DRAIN;
        end else begin
          lk_ready = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_CNT_W'(CAM_LOOKUP_LATENCY - 1) && !pipe_busy) state_nxt = WRITE;
      end
      WRITE: begin
        cam_start_write = 1'b1;
        state_nxt       = WAIT_LO;
      end
      WAIT_LO: begin
        if (!cam_ready) state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (cam_ready) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Latch the granted request onto the CAM write port; it stays put until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cam_waddr  <= '0;
      cam_wdata  <= '0;
      cam_wcare  <= '0;
    end else if (grant_any) begin
      last_grant <= grant_sel;
      cam_waddr  <= grant_sel ? req1_addr : req0_addr;
      cam_wdata  <= grant_sel ? req1_data : req0_data;
      cam_wcare  <= grant_sel ? req1_care : req0_care;
    end
  end

  // Count DRAIN cycles so the write waits out the CAM lookup latency.
  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) begin
      drain_cnt <= '0;
    end else if (drain_cnt != DRAIN_CNT_W'(CAM_LOOKUP_LATENCY - 1)) begin
      drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
    end
  end

  // Issue lookups to the CAM and carry a valid token alongside its latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      cam_lookup_data <= '0;
      lk_issue        <= 1'b0;
      tok_pipe        <= '0;
    end else begin
      lk_issue <= lk_valid && lk_ready;
      if (lk_valid && lk_ready) cam_lookup_data <= lk_data;
      tok_pipe <= {tok_pipe[CAM_LOOKUP_LATENCY-2:0], lk_issue};
    end
  end

  cam_prio_enc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prio_enc (
    .match_lines (cam_match_lines),
    .hit         (enc_hit),
    .multi       (enc_multi),
    .index       (enc_index)
  );

  // Register the encoded match lines when a token leaves the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_multi <= 1'b0;
      res_index <= '0;
    end else begin
      res_valid <= tok_pipe[CAM_LOOKUP_LATENCY-1];
      if (tok_pipe[CAM_LOOKUP_LATENCY-1]) begin
        res_hit   <= enc_hit;
        res_multi <= enc_multi;
        res_index <= enc_index;
      end
    end
  end

endmodule

// File: tb/tb_cam_controller.sv
// tb/tb_cam_controller.sv - self-checking bench for cam_controller with a behavioural CAM
module tb_cam_controller;

  localparam int AW    = 5;
  localparam int DW    = 35;
  localparam int WORDS = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req0_care, req1_data, req1_care;
  logic          lk_valid, lk_ready;
  logic [DW-1:0] lk_data;
  logic          res_valid, res_hit, res_multi;
  logic [AW-1:0] res_index;
  logic [AW-1:0] cam_waddr;
  logic [DW-1:0] cam_wdata, cam_wcare, cam_lookup_data;
  logic          cam_start_write;
  logic          cam_ready = 1'b0;
  logic [WORDS-1:0] cam_match_lines;
  logic          busy;

  always #5 clk = ~clk;

  cam_controller #(.DATA_BLOCKS(5), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_care(req0_care),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_care(req1_care),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_data(lk_data),
    .res_valid(res_valid), .res_hit(res_hit), .res_multi(res_multi), .res_index(res_index),
    .cam_waddr(cam_waddr), .cam_wdata(cam_wdata), .cam_wcare(cam_wcare),
    .cam_start_write(cam_start_write), .cam_ready(cam_ready),
    .cam_lookup_data(cam_lookup_data), .cam_match_lines(cam_match_lines), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural CAM: timed init, write busy window, two-cycle lookup latency.
  logic [DW-1:0] m_data [WORDS];
  logic [DW-1:0] m_care [WORDS];
  logic          m_vld  [WORDS];
  int            init_cnt = 0;
  int            wr_cnt   = 0;
  logic [DW-1:0] l1, l2;

  always @(posedge clk) begin
    l1 <= cam_lookup_data;
    l2 <= l1;
    if (rst) begin
      for (int i = 0; i < WORDS; i++) m_vld[i] <= 1'b0;
      init_cnt  <= 8;
      wr_cnt    <= 0;
      cam_ready <= 1'b0;
    end else if (init_cnt > 0) begin
      init_cnt <= init_cnt - 1;
      if (init_cnt == 1) cam_ready <= 1'b1;
    end else if (cam_start_write) begin
      cam_ready <= 1'b0;
      wr_cnt    <= 3;
    end else if (wr_cnt > 0) begin
      wr_cnt <= wr_cnt - 1;
      if (wr_cnt == 1) begin
        m_data[cam_waddr] <= cam_wdata;
        m_care[cam_waddr] <= cam_wcare;
        m_vld[cam_waddr]  <= 1'b1;
        cam_ready         <= 1'b1;
      end
    end
  end

  always_comb begin
    cam_match_lines = '0;
    for (int i = 0; i < WORDS; i++)
      cam_match_lines[i] = m_vld[i] && (((l2 ^ m_data[i]) & m_care[i]) == '0);
  end

  // Reference model: table shadow updated at write acceptance, results as an ordered queue.
  typedef struct {
    logic          hit;
    logic          multi;
    logic [AW-1:0] idx;
    int            due;
  } res_t;

  res_t          exp_q[$];
  res_t          res_log[$];
  int            grant_log[$];
  logic [DW-1:0] pool[$];
  logic [DW-1:0] r_data [WORDS];
  logic [DW-1:0] r_care [WORDS];
  bit            r_vld  [WORDS];
  bit            r_last = 1'b1;
  res_t          e, a;
  int            wr_acc_cyc = -100;
  logic [AW-1:0] wr_addr_exp;
  logic [DW-1:0] wr_data_exp, wr_care_exp;
  int            sw_count   = 0;
  int            rdy0_count = 0;
  int            g, exp_g;

  function automatic res_t ref_lookup(input logic [DW-1:0] key);
    res_t r;
    int   n = 0;
    r.idx = '0;
    r.due = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_vld[i] && ((key ^ r_data[i]) & r_care[i]) == '0) begin
        if (n == 0) r.idx = AW'(i);
        n++;
      end
    end
    r.hit   = (n > 0);
    r.multi = (n > 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (res_valid) begin
      check("res_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_cycle", cyc, e.due);
        check("res_hit", res_hit, e.hit);
        check("res_multi", res_multi, e.multi);
        check("res_index", res_index, e.idx);
        a.hit = res_hit; a.multi = res_multi; a.idx = res_index; a.due = cyc;
        res_log.push_back(a);
      end
    end
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < WORDS; i++) r_vld[i] = 1'b0;
      r_last = 1'b1;
    end else begin
      if (req0_ready || req1_ready) begin
        check("ready_onehot", req0_ready && req1_ready, 0);
        g     = req1_ready ? 1 : 0;
        exp_g = (req0_valid && req1_valid) ? int'(!r_last) : int'(req1_valid);
        check("grant_rr", g, exp_g);
        check("grant_has_valid", g ? req1_valid : req0_valid, 1);
        check("grant_blocks_lookup", lk_ready, 0);
        r_last      = g[0];
        wr_addr_exp = g ? req1_addr : req0_addr;
        wr_data_exp = g ? req1_data : req0_data;
        wr_care_exp = g ? req1_care : req0_care;
        r_data[wr_addr_exp] = wr_data_exp;
        r_care[wr_addr_exp] = wr_care_exp;
        r_vld[wr_addr_exp]  = 1'b1;
        grant_log.push_back(g);
        wr_acc_cyc = cyc;
      end
      if (req0_ready) rdy0_count++;
      if (lk_valid && lk_ready) begin
        e     = ref_lookup(lk_data);
        e.due = cyc + 4;
        exp_q.push_back(e);
      end
      if (cam_start_write) begin
        sw_count++;
        check("sw_cycle", cyc, wr_acc_cyc + 3);
        check("sw_lookups_drained", exp_q.size(), 0);
        check("sw_addr", cam_waddr, wr_addr_exp);
        check("sw_data", cam_wdata, wr_data_exp);
        check("sw_care", cam_wcare, wr_care_exp);
      end
      if (busy) check("lk_ready_while_busy", lk_ready, 0);
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 1);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_lk_ready", lk_ready, 0);
    check("rst_start_write", cam_start_write, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_hit", res_hit, 0);
    check("rst_res_multi", res_multi, 0);
    check("rst_res_index", res_index, 0);
    check("rst_cam_waddr", cam_waddr, 0);
    check("rst_cam_wdata", cam_wdata, 0);
    check("rst_cam_wcare", cam_wcare, 0);
    check("rst_lookup_data", cam_lookup_data, 0);
  endtask

  task automatic wait_init();
    int rc   = -100;
    bit seen = 1'b0;
    bit done = 1'b0;
    int rv   = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (res_valid) rv++;
      if (!busy) begin
        check("init_exit_cycle", cyc, rc + 1);
        done = 1'b1;
      end else if (!seen && cam_ready) begin
        seen = 1'b1;
        rc   = cyc;
      end
    end
    check("init_done", done, 1);
    check("init_no_result", rv, 0);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check("idle_reached", done, 1);
  endtask

  task automatic do_write(input bit p, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                          input logic [DW-1:0] c);
    int sw0 = sw_count;
    int r0  = rdy0_count;
    bit ok  = 1'b0;
    tick();
    if (p) begin
      req1_valid = 1'b1; req1_addr = ad; req1_data = d; req1_care = c;
    end else begin
      req0_valid = 1'b1; req0_addr = ad; req0_data = d; req0_care = c;
    end
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = p ? req1_ready : req0_ready;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("wr_accept", ok, 1);
    wait_idle();
    check("wr_start_pulses", sw_count - sw0, 1);
    if (!p) check("wr_req0_ready_once", rdy0_count - r0, 1);
  endtask

  task automatic lookup_once(input logic [DW-1:0] key);
    lk_valid = 1'b1;
    lk_data  = key;
    @(negedge clk);
    check("lk_accept", lk_ready, 1);
    tick();
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_care();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return {{(DW-8){1'b1}}, 8'h00};
      2:       return {{(DW-16){1'b1}}, 16'h0000};
      default: return rand_data() | {{(DW-20){1'b1}}, 20'h0};
    endcase
  endfunction

  function automatic logic [DW-1:0] rand_key();
    if (pool.size() == 0 || $urandom_range(0, 3) == 0) return rand_data();
    return pool[$urandom_range(0, pool.size() - 1)] ^
           DW'($urandom_range(0, 1) ? 0 : $urandom_range(0, 255));
  endfunction

  typedef struct {
    bit            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] care;
  } wr_vec_t;

  typedef struct {
    logic [DW-1:0] key;
    logic          hit;
    logic          multi;
    logic [AW-1:0] idx;
  } lk_vec_t;

  wr_vec_t wr_tab[4];
  lk_vec_t lk_tab[5];
  int      rr_exp[4];

  initial begin
    int  base, g0, n;
    bit  ok, a0, a1, al;

    wr_tab[0] = '{1'b0, 5'd0,  35'h0e3d21200, 35'hfffffff00};
    wr_tab[1] = '{1'b0, 5'd5,  35'h013d20000, 35'hfffff0000};
    wr_tab[2] = '{1'b0, 5'd7,  35'h001050aff, 35'h7ffffffff};
    wr_tab[3] = '{1'b1, 5'd31, 35'h013d20100, 35'hfffffff00};
    lk_tab[0] = '{35'h001050aff, 1'b1, 1'b0, 5'd7};
    lk_tab[1] = '{35'h013d21234, 1'b1, 1'b0, 5'd5};
    lk_tab[2] = '{35'h013d20134, 1'b1, 1'b1, 5'd5};
    lk_tab[3] = '{35'h0f3d21212, 1'b0, 1'b0, 5'd0};
    lk_tab[4] = '{35'h0e3d21212, 1'b1, 1'b0, 5'd0};
    rr_exp    = '{0, 1, 0, 1};

    req0_valid = 0; req0_addr = 0; req0_data = 0; req0_care = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0; req1_care = 0;
    lk_valid   = 0; lk_data   = 0;

    rst = 1'b1;
    repeat (3) tick();
    check_reset_values();
    rst = 1'b0;
    wait_init();

    for (int i = 0; i < 4; i++) do_write(wr_tab[i].port, wr_tab[i].addr, wr_tab[i].data, wr_tab[i].care);

    tick();
    base = res_log.size();
    for (int i = 0; i < 5; i++) lookup_once(lk_tab[i].key);
    lk_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("lk_table_count", res_log.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < res_log.size()) begin
        check("lk_table_hit", res_log[base+i].hit, lk_tab[i].hit);
        check("lk_table_multi", res_log[base+i].multi, lk_tab[i].multi);
        check("lk_table_index", res_log[base+i].idx, lk_tab[i].idx);
      end
    end

    tick();
    g0 = grant_log.size();
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 35'h123456789; req0_care = '1;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 35'h2468ace01; req1_care = '1;
    n = 0;
    while (grant_log.size() - g0 < 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("rr_grant_count", grant_log.size() - g0, 4);
    for (int i = 0; i < 4; i++)
      if (g0 + i < grant_log.size()) check("rr_grant_order", grant_log[g0+i], rr_exp[i]);

    tick();
    lookup_once(35'h123456789);
    lookup_once(35'h2468ace01);
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 35'h0000000ab; req0_care = '1;
    lk_data    = 35'h0000000ab;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = req0_ready;
    end
    check("mid_lookup_write_accept", ok, 1);
    tick();
    req0_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = lk_ready;
    end
    check("stalled_lookup_accept", ok, 1);
    tick();
    lk_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("stalled_lookup_result", res_log[res_log.size()-1].hit, 1);

    do_write(1'b0, 5'd3, 35'h055555555, '1);
    tick();
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 35'h0aaaaaaaa; req0_care = '1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = cam_start_write;
    end
    check("wait_hi_start_seen", ok, 1);
    req0_valid = 1'b0;
    @(posedge clk);
    tick();
    check("wait_hi_cam_low", cam_ready, 0);
    rst = 1'b1;
    repeat (2) tick();
    check_reset_values();
    rst = 1'b0;
    wait_init();

    tick();
    lk_valid = 1'b1;
    lk_data  = 35'h0e3d21200;
    tick();
    lk_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) tick();
    check_reset_values();
    rst = 1'b0;
    base = res_log.size();
    wait_init();
    check("reset_drops_token", res_log.size() - base, 0);

    a0 = 1'b0; a1 = 1'b0; al = 1'b0;
    tick();
    for (int it = 0; it < 2000; it++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      al = lk_valid && lk_ready;
      tick();
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 11) == 0);
        req0_addr  = AW'($urandom_range(0, WORDS - 1));
        req0_data  = rand_data();
        req0_care  = rand_care();
        if (req0_valid) pool.push_back(req0_data);
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 11) == 0);
        req1_addr  = AW'($urandom_range(0, WORDS - 1));
        req1_data  = rand_data();
        req1_care  = rand_care();
        if (req1_valid) pool.push_back(req1_data);
      end
      if (!lk_valid || al) begin
        lk_valid = ($urandom_range(0, 3) != 0);
        lk_data  = rand_key();
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lk_valid   = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
